// File: rtl/nonce_collector_pkg.sv
// Shared constants and state encoding for the nonce collector and its tag FIFO.
package nonce_collector_pkg;

  localparam int NONCE_W = 32;
  localparam int HASH_W  = 256;

  localparam logic [NONCE_W-1:0] NONCE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED
  } state_e;

endpackage

// File: rtl/nonce_collector_tag_fifo.sv
// In-order FIFO of issued nonces awaiting their hash results; flush empties it.
module nonce_tag_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int NONCE_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [NONCE_W-1:0]            din,
  output logic [NONCE_W-1:0]            head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NONCE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/nonce_collector.sv
// Issues nonces to the SHA core, matches results in order and latches the first hit.
// Optional NONCE_COLLECTOR_STATS_EN adds hash_count/hit_count statistics outputs.
module nonce_collector #(
  parameter int NONCE_W    = nonce_collector_pkg::NONCE_W,
  parameter int HASH_W     = nonce_collector_pkg::HASH_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic [NONCE_W-1:0] nonce_in,
  output logic               update,
  input  logic               hash_valid,
  input  logic [HASH_W-1:0]  hash,
  input  logic [HASH_W-1:0]  target,
  output logic               busy,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               exhausted,
  output logic               err_underflow
`ifdef NONCE_COLLECTOR_STATS_EN
  ,
  output logic [31:0]        hash_count,
  output logic [7:0]         hit_count
`endif
);

  import nonce_collector_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic               last_issued_q, last_issued_d;
  logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
  logic               err_q, err_d;

  logic [NONCE_W-1:0] head;
  logic [CW-1:0]      count;
  logic               full, fifo_empty, pop, hit, flush, push_last;

  assign fifo_empty = (count == '0);
  assign pop        = hash_valid && !fifo_empty;
  assign hit        = pop && (hash <= target);
  assign update     = (state_q == S_RUN) && !full && !last_issued_q;
  assign push_last  = update && (&nonce_in);
  assign flush      = clear && ((state_q == S_FOUND) || (state_q == S_EXHAUSTED));

  nonce_tag_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .NONCE_W    (NONCE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (update),
    .pop   (pop),
    .flush (flush),
    .din   (nonce_in),
    .head  (head),
    .count (count),
    .full  (full)
  );

  always_comb begin
    state_d       = state_q;
    last_issued_d = last_issued_q;
    found_nonce_d = found_nonce_q;
    err_d         = err_q;
    if (hash_valid && fifo_empty) err_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RUN;
          last_issued_d = 1'b0;
        end
      end
      S_RUN: begin
        if (push_last) last_issued_d = 1'b1;
        if (hit) begin
          state_d       = S_FOUND;
          found_nonce_d = head;
        end else if (stop || push_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No pushes happen in DRAIN, so the FIFO empties this edge when count equals pop.
        if (hit) begin
          state_d       = S_FOUND;
          found_nonce_d = head;
        end else if (count == CW'(pop)) begin
          state_d = S_EXHAUSTED;
        end
      end
      S_FOUND, S_EXHAUSTED: begin
        if (clear) begin
          state_d       = S_IDLE;
          found_nonce_d = '0;
          err_d         = 1'b0;
          last_issued_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      last_issued_q <= 1'b0;
      found_nonce_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_issued_q <= last_issued_d;
      found_nonce_q <= found_nonce_d;
      err_q         <= err_d;
    end
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign found         = (state_q == S_FOUND);
  assign exhausted     = (state_q == S_EXHAUSTED);
  assign found_nonce   = found_nonce_q;
  assign err_underflow = err_q;

`ifdef NONCE_COLLECTOR_STATS_EN
  logic [31:0] hash_count_q, hash_count_d;
  logic [7:0]  hit_count_q, hit_count_d;

  always_comb begin
    hash_count_d = hash_count_q;
    hit_count_d  = hit_count_q;
    if (start && (state_q == S_IDLE)) begin
      hash_count_d = '0;
      hit_count_d  = '0;
    end else begin
      if (pop && (hash_count_q != '1)) hash_count_d = hash_count_q + 1'b1;
      if (hit && (hit_count_q != '1))  hit_count_d  = hit_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hash_count_q <= '0;
      hit_count_q  <= '0;
    end else begin
      hash_count_q <= hash_count_d;
      hit_count_q  <= hit_count_d;
    end
  end

  assign hash_count = hash_count_q;
  assign hit_count  = hit_count_q;
`endif

endmodule

// File: tb/tb_nonce_collector.sv
// Directed self-checking bench for nonce_collector with a behavioural incrementer.
module tb_nonce_collector;
  import nonce_collector_pkg::*;

  localparam int NW = 32;
  localparam int HW = 256;

  logic          clk = 1'b0;
  logic          reset, start, stop, clear, hash_valid;
  logic          update, busy, found, exhausted, err_underflow;
  logic [NW-1:0] nonce_in, found_nonce, inc_ld_val;
  logic [HW-1:0] hash, target, miss_h;
  logic          inc_ld;
  int            checks = 0;
  int            failures = 0;
  int            cnt;

  always #5 clk = ~clk;

  // Incrementer model: advances on every update strobe, loadable from the bench.
  always @(posedge clk) begin
    if (inc_ld) nonce_in <= inc_ld_val;
    else if (update) nonce_in <= nonce_in + 1'b1;
  end

  nonce_collector #(
    .NONCE_W    (NW),
    .HASH_W     (HW),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .clear         (clear),
    .nonce_in      (nonce_in),
    .update        (update),
    .hash_valid    (hash_valid),
    .hash          (hash),
    .target        (target),
    .busy          (busy),
    .found         (found),
    .found_nonce   (found_nonce),
    .exhausted     (exhausted),
    .err_underflow (err_underflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_inc(input logic [NW-1:0] v);
    inc_ld = 1'b1; inc_ld_val = v; step(); inc_ld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic result(input logic [HW-1:0] h);
    hash_valid = 1'b1; hash = h; step(); hash_valid = 1'b0;
  endtask

  task automatic count_updates(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (update) c++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    hash_valid = 1'b0; hash = '0; inc_ld = 1'b1; inc_ld_val = '0;
    target = '0; target[240] = 1'b1;
    miss_h = target + 5;
    step(); step();
    reset = 1'b1; inc_ld = 1'b0;
    step();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_update", 64'(update), 64'd0);
    check_eq("rst_found", 64'(found), 64'd0);
    check_eq("rst_exh", 64'(exhausted), 64'd0);
    check_eq("rst_err", 64'(err_underflow), 64'd0);
    check_eq("rst_fnonce", 64'(found_nonce), 64'd0);

    // Basic search: nonces 0,1 miss, nonce 2 hits
    load_inc('0);
    pulse_start();
    check_eq("t1_first_update", 64'(update), 64'd1);
    step(); step(); step();
    result('1);
    result(miss_h);
    result(256'd1);
    check_eq("t1_found", 64'(found), 64'd1);
    check_eq("t1_fnonce", 64'(found_nonce), 64'd2);
    check_eq("t1_busy", 64'(busy), 64'd0);
    count_updates(4, cnt);
    check_eq("t1_no_update", 64'(cnt), 64'd0);
    pulse_clear();
    check_eq("t1_clr_found", 64'(found), 64'd0);
    check_eq("t1_clr_fnonce", 64'(found_nonce), 64'd0);
    check_eq("t1_err", 64'(err_underflow), 64'd0);

    // Exhaustion from the top of the nonce space
    load_inc(NONCE_MAX - 2);
    pulse_start();
    count_updates(6, cnt);
    check_eq("t3_pushes", 64'(cnt), 64'd3);
    check_eq("t3_busy", 64'(busy), 64'd1);
    check_eq("t3_exh_early", 64'(exhausted), 64'd0);
    result('1);
    result('1);
    check_eq("t3_exh_2pops", 64'(exhausted), 64'd0);
    result('1);
    check_eq("t3_exh", 64'(exhausted), 64'd1);
    check_eq("t3_busy_done", 64'(busy), 64'd0);
    pulse_clear();
    check_eq("t3_clr_exh", 64'(exhausted), 64'd0);

    // stop with the fifth push, third result hits exactly at target
    load_inc(32'h50);
    pulse_start();
    step(); step(); step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    check_eq("t4_update_off", 64'(update), 64'd0);
    check_eq("t4_drain_busy", 64'(busy), 64'd1);
    result(target + 1);
    result('1);
    result(target);
    check_eq("t4_found", 64'(found), 64'd1);
    check_eq("t4_fnonce", 64'(found_nonce), 64'h52);
    result('0);
    result('0);
    check_eq("t4_first_wins", 64'(found_nonce), 64'h52);
    pulse_clear();

    // stop after five issues, no hit
    load_inc(32'h70);
    pulse_start();
    step(); step(); step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 4; i++) result(target + 1);
    check_eq("t4b_exh_4pops", 64'(exhausted), 64'd0);
    result(target + 1);
    check_eq("t4b_exh", 64'(exhausted), 64'd1);
    check_eq("t4b_found", 64'(found), 64'd0);
    pulse_clear();

    // hash_valid with empty FIFO in RUN sets the sticky error
    load_inc('0);
    pulse_start();
    stop = 1'b1; hash_valid = 1'b1; hash = '0;
    step();
    stop = 1'b0; hash_valid = 1'b0;
    check_eq("t5_err", 64'(err_underflow), 64'd1);
    check_eq("t5_no_false_hit", 64'(found), 64'd0);
    result('1);
    check_eq("t5_exh_one_entry", 64'(exhausted), 64'd1);
    check_eq("t5_err_sticky", 64'(err_underflow), 64'd1);
    pulse_clear();
    check_eq("t5_err_clr", 64'(err_underflow), 64'd0);
    check_eq("t5_idle_busy", 64'(busy), 64'd0);

    // Backpressure: 16 in flight, one result frees exactly one slot
    load_inc('0);
    pulse_start();
    count_updates(20, cnt);
    check_eq("t2_fill", 64'(cnt), 64'd16);
    result('1);
    count_updates(5, cnt);
    check_eq("t2_one_more", 64'(cnt), 64'd1);

    // Reset mid-search with the FIFO full
    reset = 1'b0; step(); reset = 1'b1;
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_update", 64'(update), 64'd0);
    check_eq("t6_found", 64'(found), 64'd0);
    load_inc(32'h200);
    pulse_start();
    count_updates(20, cnt);
    check_eq("t6_refill", 64'(cnt), 64'd16);
    stop = 1'b1; step(); stop = 1'b0;
    result('0);
    check_eq("t6_found_after", 64'(found), 64'd1);
    check_eq("t6_fnonce", 64'(found_nonce), 64'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
